// File: rtl/poly_eval_horner_if.sv
// poly_eval_horner_if: load/result bus for poly_eval_horner; the overflow wire exists only with POLY_OVF_EN.
interface poly_eval_horner_if #(parameter int WIDTH = 8);
  logic             go;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_result;
  logic             busy;
  logic             done;
`ifdef POLY_OVF_EN
  logic             overflow;
  modport master (output go, data_in, input data_result, busy, done, overflow);
  modport slave  (input go, data_in, output data_result, busy, done, overflow);
`else
  modport master (output go, data_in, input data_result, busy, done);
  modport slave  (input go, data_in, output data_result, busy, done);
`endif
endinterface

// File: rtl/poly_eval_horner.sv
// poly_eval_horner: Horner evaluation with one shared multiply/add step per cycle; POLY_OVF_EN adds a sticky Overflow flag.
module poly_eval_horner #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 3
) (
  input logic             clk,
  input logic             rst_n,
  poly_eval_horner_if.slave bus
);
  localparam int SW = $clog2(DEGREE + 2);
  localparam int KW = $clog2(DEGREE + 1);
`ifdef POLY_OVF_EN
  localparam int EW = 1;
`else
  localparam int EW = 0;
`endif
  localparam int PW   = WIDTH * (1 + EW);
  localparam int SUMW = WIDTH + EW;
  localparam logic [2:0] S_LOAD      = 3'd0;
  localparam logic [2:0] S_LOAD_WAIT = 3'd1;
  localparam logic [2:0] S_MUL       = 3'd2;
  localparam logic [2:0] S_ADD       = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]       state;
  logic [SW-1:0]    slot;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] mem [DEGREE+2];
  logic             arm;
  logic             capture;
  logic [SW-1:0]    ck_idx;
  logic [PW-1:0]    prod;
  logic [SUMW-1:0]  sum;

  // slot 0 holds c_N, slot N holds c_0, slot N+1 holds x
  assign ck_idx  = SW'(DEGREE) - SW'(k);
  assign prod    = PW'(acc) * PW'(mem[DEGREE+1]);
  assign sum     = SUMW'(acc) + SUMW'(mem[ck_idx]);
  assign capture = state == S_LOAD && bus.go && arm;

  assign bus.busy        = state == S_MUL || state == S_ADD || state == S_DONE;
  assign bus.done        = state == S_DONE;
  assign bus.data_result = result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_LOAD;
      slot   <= '0;
      k      <= '0;
      acc    <= '0;
      result <= '0;
      arm    <= 1'b1;
      for (int i = 0; i < DEGREE + 2; i++) mem[i] <= '0;
    end else begin
      // a Go still high when evaluation finishes must drop before the next capture
      arm <= (state == S_DONE) ? 1'b0 : (!bus.go ? 1'b1 : arm);
      case (state)
        S_LOAD: if (capture) begin
          mem[slot] <= bus.data_in;
          state     <= S_LOAD_WAIT;
        end
        S_LOAD_WAIT: if (!bus.go) begin
          if (slot == SW'(DEGREE + 1)) begin
            acc   <= mem[0];
            k     <= KW'(DEGREE - 1);
            state <= S_MUL;
          end else begin
            slot  <= slot + 1'b1;
            state <= S_LOAD;
          end
        end
        S_MUL: begin
          acc   <= prod[WIDTH-1:0];
          state <= S_ADD;
        end
        S_ADD: begin
          acc <= sum[WIDTH-1:0];
          if (k == '0) begin
            result <= sum[WIDTH-1:0];
            state  <= S_DONE;
          end else begin
            k     <= k - 1'b1;
            state <= S_MUL;
          end
        end
        S_DONE: begin
          slot  <= '0;
          state <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

`ifdef POLY_OVF_EN
  logic sticky;
  logic ovf_q;

  assign bus.overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (capture && slot == '0) sticky <= 1'b0;
      else if (state == S_MUL && |prod[PW-1:WIDTH]) sticky <= 1'b1;
      else if (state == S_ADD && sum[WIDTH]) sticky <= 1'b1;
      if (state == S_ADD && k == '0) ovf_q <= sticky | sum[WIDTH];
    end
  end
`endif
endmodule

// File: tb/tb_poly_eval_horner.sv
// tb_poly_eval_horner: directed loads on a degree-3 and a degree-1 evaluator, checked every cycle against a power-sum model.
module tb_poly_eval_horner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_eval_horner_if #(.WIDTH(8)) ifa ();
  poly_eval_horner_if #(.WIDTH(8)) ifb ();

  poly_eval_horner #(.WIDTH(8), .DEGREE(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  poly_eval_horner #(.WIDTH(8), .DEGREE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks = 0;
  int errors = 0;
  int nd [2] = '{3, 1};
  bit launch [2];
  bit act [2];
  int j [2];
  logic [7:0] pend_res [2];
  logic [7:0] exp_res [2];
  bit pend_ovf [2];
  bit exp_ovf [2];
  logic [7:0] r_res;
  logic r_b, r_dn;
  bit e_b, e_dn;
  int bc, dc;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // p(x) as a plain sum of c_k * x^k, everything mod 256
  function automatic logic [7:0] poly(input int n, input logic [7:0] w [5]);
    int s, pw;
    s = 0;
    pw = 1;
    for (int i = 0; i <= n; i++) begin
      s  = (s + int'(w[n-i]) * pw) & 255;
      pw = (pw * int'(w[n+1])) & 255;
    end
    return s[7:0];
  endfunction

  // overflow: any full product >= 256 or any sum carrying out along the Horner chain
  function automatic bit horner_ovf(input int n, input logic [7:0] w [5]);
    int a;
    bit o;
    a = int'(w[0]);
    o = 1'b0;
    for (int i = 1; i <= n; i++) begin
      a = a * int'(w[n+1]);
      if (a > 255) o = 1'b1;
      a = (a & 255) + int'(w[i]);
      if (a > 255) o = 1'b1;
      a = a & 255;
    end
    return o;
  endfunction

  task automatic drive(input int d, input logic g, input logic [7:0] v);
    if (d == 0) begin
      ifa.go = g;
      ifa.data_in = v;
    end else begin
      ifb.go = g;
      ifb.data_in = v;
    end
  endtask

  // w holds c_N..c_0 then x; each word is held for 'hold' cycles
  task automatic load_poly(input int d, input logic [7:0] w [5], input int hold);
    for (int i = 0; i <= nd[d] + 1; i++) begin
      @(posedge clk);
      #1 drive(d, 1'b1, w[i]);
      repeat (hold) @(posedge clk);
      #1 drive(d, 1'b0, w[i]);
      if (i == nd[d] + 1) begin
        pend_res[d] = poly(nd[d], w);
        pend_ovf[d] = horner_ovf(nd[d], w);
        launch[d] = 1'b1;
      end
    end
  endtask

  task automatic wait_eval(input int d, output int busy_cnt, output int done_cnt);
    bit seen, b, dn;
    seen = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      b  = (d == 0) ? ifa.busy : ifb.busy;
      dn = (d == 0) ? ifa.done : ifb.done;
      if (b) busy_cnt++;
      if (dn) begin
        done_cnt++;
        seen = 1'b1;
      end
      if (seen && !b) break;
    end
    if (!seen) chk($sformatf("eval_timeout%0d", d), 0, 1);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      r_res = (d == 0) ? ifa.data_result : ifb.data_result;
      r_b   = (d == 0) ? ifa.busy : ifb.busy;
      r_dn  = (d == 0) ? ifa.done : ifb.done;
      e_b   = 1'b0;
      e_dn  = 1'b0;
      if (!rst_n) begin
        act[d] = 1'b0;
        launch[d] = 1'b0;
        exp_res[d] = 8'h00;
        exp_ovf[d] = 1'b0;
      end else begin
        if (launch[d]) begin
          launch[d] = 1'b0;
          act[d] = 1'b1;
          j[d] = -1;
        end else if (act[d]) j[d]++;
        e_b  = act[d] && j[d] >= 0;
        e_dn = act[d] && j[d] == 2 * nd[d];
        if (e_dn) begin
          exp_res[d] = pend_res[d];
          exp_ovf[d] = pend_ovf[d];
          act[d] = 1'b0;
        end
      end
      chk($sformatf("busy%0d", d), int'(r_b), int'(e_b));
      chk($sformatf("done%0d", d), int'(r_dn), int'(e_dn));
      chk($sformatf("result%0d", d), int'(r_res), int'(exp_res[d]));
`ifdef POLY_OVF_EN
      chk($sformatf("overflow%0d", d), int'((d == 0) ? ifa.overflow : ifb.overflow), int'(exp_ovf[d]));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    #22 rst_n = 1'b1;

    load_poly(0, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd2}, 1);
    wait_eval(0, bc, dc);
    chk("t1_result", int'(ifa.data_result), 8'h1A);
    chk("t1_done_pulses", dc, 1);
    chk("t1_busy_cycles", bc, 7);
`ifdef POLY_OVF_EN
    chk("t1_ovf", int'(ifa.overflow), 0);
`endif

    load_poly(0, '{8'd1, 8'd0, 8'd0, 8'd0, 8'd16}, 1);
    wait_eval(0, bc, dc);
    chk("t2_result", int'(ifa.data_result), 8'h00);
`ifdef POLY_OVF_EN
    chk("t2_ovf", int'(ifa.overflow), 1);
`endif

    load_poly(0, '{8'd0, 8'd0, 8'd0, 8'd5, 8'd3}, 1);
    wait_eval(0, bc, dc);
    chk("t3_result", int'(ifa.data_result), 8'h05);
`ifdef POLY_OVF_EN
    chk("t3_ovf", int'(ifa.overflow), 0);
`endif

    load_poly(1, '{8'd3, 8'd5, 8'd7, 8'd0, 8'd0}, 1);
    wait_eval(1, bc, dc);
    chk("t4_result", int'(ifb.data_result), 26);
    chk("t4_busy_cycles", bc, 3);
    chk("t4_done_pulses", dc, 1);

    load_poly(1, '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0}, 2);
    wait_eval(1, bc, dc);
    chk("t5_result", int'(ifb.data_result), 0);

    load_poly(0, '{8'hFF, 8'h80, 8'd7, 8'd9, 8'h13}, 3);
    wait_eval(0, bc, dc);
    chk("t6_result", int'(ifa.data_result), 67);

    load_poly(0, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd2}, 10);
    fork
      wait_eval(0, bc, dc);
      begin
        for (int i = 0; i < 6; i++) begin
          @(posedge clk);
          #1 drive(0, (i % 2) == 0, 8'hEE);
        end
        @(posedge clk);
        #1 drive(0, 1'b1, 8'hEE);
        repeat (6) @(posedge clk);
        #1 drive(0, 1'b0, 8'hEE);
      end
    join
    chk("t7_result", int'(ifa.data_result), 8'h1A);
    chk("t7_done_pulses", dc, 1);
    chk("t7_busy_cycles", bc, 7);

    load_poly(0, '{8'd0, 8'd0, 8'd1, 8'd0, 8'd5}, 1);
    wait_eval(0, bc, dc);
    chk("t7b_result", int'(ifa.data_result), 8'h05);

    load_poly(0, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd2}, 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_result", int'(ifa.data_result), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_done", int'(ifa.done), 0);
`ifdef POLY_OVF_EN
    chk("rst_ovf", int'(ifa.overflow), 0);
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    load_poly(0, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd2}, 1);
    wait_eval(0, bc, dc);
    chk("t8_result", int'(ifa.data_result), 8'h1A);
    chk("t8_done_pulses", dc, 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
